// File: rtl/bulk_ep_in_packetiser.sv
// bulk_ep_in_packetiser
//
// Bulk IN endpoint buffer on the USB clock. It accepts an 8-bit AXI-Stream,
// stores each byte with its frame-last flag, and hands USB-sized packets to
// the transaction layer. A packet is only removed from the buffer once its
// last byte has been handed over. An aborted transfer rewinds the read
// pointer, so the next transfer replays the same bytes.
//
// Parameters
//   DEPTH        buffer entries (power of two, >= MAX_PKT)
//   MAX_PKT      maximum bytes per IN packet
//   PACKET_MODE  1 = packet mode, 0 = streaming
//   TIMEOUT      idle cycles before partial data is flushed (0 = never)
//
// Ports
//   clock, reset_n                      USB clock, async active-low reset
//   s_tvalid_i/s_tready_o/s_tlast_i     input stream handshake, frame end
//   s_tdata_i                           input byte
//   ep_xfer_i                           bulk IN transfer active
//   ep_has_data_o                       a packet is ready to send
//   ep_tvalid_o/ep_tready_i/ep_tlast_o  packet stream to the transaction layer
//   ep_tdata_o                          packet byte
//   level_o                             committed occupancy
//   full_o                              buffer full
module bulk_ep_in_packetiser #(
    parameter int DEPTH       = 2048,
    parameter int MAX_PKT     = 512,
    parameter int PACKET_MODE = 1,
    parameter int TIMEOUT     = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     s_tvalid_i,
    output logic                     s_tready_o,
    input  logic                     s_tlast_i,
    input  logic [7:0]               s_tdata_i,
    input  logic                     ep_xfer_i,
    output logic                     ep_has_data_o,
    output logic                     ep_tvalid_o,
    input  logic                     ep_tready_i,
    output logic                     ep_tlast_o,
    output logic [7:0]               ep_tdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKT) + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT
    } state_t;

    state_t state, state_next;

    logic [8:0]    mem [DEPTH];
    logic [PW-1:0] wp, cp, rp, start, frames, level, rp_inc;
    logic [TW-1:0] timer;
    logic [CW-1:0] snap, cnt;
    logic [8:0]    dout;
    logic          full, wr_en, big, flush, ready_rule, tlast, send_hs, last_hs;

    assign level  = wp - cp;
    assign full   = (level == PW'(DEPTH));
    assign rp_inc = rp + PW'(1);
    assign wr_en  = s_tvalid_i && !full;
    assign big    = (level >= PW'(MAX_PKT));
    assign flush  = (TIMEOUT != 0) && (timer == TW'(TIMEOUT)) && (level != '0);

    // Both modes release a packet on a complete frame, a full packet's
    // worth of data, or an idle flush of a partial packet.
    assign ready_rule = (PACKET_MODE != 0) ? ((frames != '0) || big || flush)
                                           : (big || flush || (frames != '0));

    // A packet ends on the first byte carrying the frame flag, or on the
    // last byte of the length snapshot taken when the transfer started.
    assign tlast   = (state == SEND) && (dout[8] || (cnt == snap - CW'(1)));
    assign send_hs = (state == SEND) && ep_xfer_i && ep_tready_i;
    assign last_hs = send_hs && tlast;

    assign s_tready_o    = !full;
    assign full_o        = full;
    assign level_o       = level;
    assign ep_has_data_o = (state == IDLE) && ready_rule;
    assign ep_tvalid_o   = (state == SEND);
    assign ep_tlast_o    = tlast;
    assign ep_tdata_o    = dout[7:0];

    // Storage has no reset: the pointers define which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wp[AW-1:0]] <= {s_tlast_i, s_tdata_i};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Any drop of ep_xfer_i before the last handshake abandons the packet.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (ep_xfer_i && ready_rule) state_next = LOAD;
            LOAD: state_next = ep_xfer_i ? SEND : IDLE;
            SEND: begin
                if (!ep_xfer_i) begin
                    state_next = IDLE;
                end else if (ep_tready_i && tlast) begin
                    state_next = WAIT;
                end
            end
            WAIT: if (!ep_xfer_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pointer and read datapath. The output byte register is always one
    // entry ahead of the handshake, so a stalled beat keeps data stable
    // and a taken beat immediately exposes the next byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            cp    <= '0;
            rp    <= '0;
            start <= '0;
            snap  <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            if (wr_en) begin
                wp <= wp + PW'(1);
            end
            case (state)
                IDLE: begin
                    if (state_next == LOAD) begin
                        start <= cp;
                        snap  <= big ? CW'(MAX_PKT) : CW'(level);
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (!ep_xfer_i) begin
                        rp <= start;
                    end else begin
                        dout <= mem[rp[AW-1:0]];
                    end
                end
                SEND: begin
                    if (!ep_xfer_i) begin
                        rp <= start;
                    end else if (ep_tready_i) begin
                        rp   <= rp_inc;
                        cnt  <= cnt + CW'(1);
                        dout <= mem[rp_inc[AW-1:0]];
                        if (tlast) begin
                            cp <= rp_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame count covers every buffered frame end; it only drops when a
    // committed packet closed a frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frames <= '0;
        end else begin
            case ({wr_en && s_tlast_i, last_hs && dout[8]})
                2'b10:   frames <= frames + PW'(1);
                2'b01:   frames <= frames - PW'(1);
                default: frames <= frames;
            endcase
        end
    end

    // Idle timer: restarts on every write, saturates once the flush point
    // is reached. Commits deliberately leave it alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (wr_en) begin
            timer <= '0;
        end else if ((level != '0) && (timer != TW'(TIMEOUT))) begin
            timer <= timer + TW'(1);
        end
    end

endmodule

// File: tb/tb_bulk_ep_in_packetiser.sv
// tb_bulk_ep_in_packetiser
//
// Self-checking bench for bulk_ep_in_packetiser. A queue holds the bytes the
// buffer should contain; each transfer derives its expected packet from that
// queue and pushes it to a scoreboard that a negedge monitor drains.
module tb_bulk_ep_in_packetiser;

    localparam int DEPTH       = 32;
    localparam int MAX_PKT     = 8;
    localparam int PACKET_MODE = 1;
    localparam int TIMEOUT     = 20;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   s_tvalid_i = 1'b0;
    logic                   s_tready_o;
    logic                   s_tlast_i = 1'b0;
    logic [7:0]             s_tdata_i = '0;
    logic                   ep_xfer_i = 1'b0;
    logic                   ep_has_data_o;
    logic                   ep_tvalid_o;
    logic                   ep_tready_i = 1'b0;
    logic                   ep_tlast_o;
    logic [7:0]             ep_tdata_o;
    logic [$clog2(DEPTH):0] level_o;
    logic                   full_o;

    logic [8:0] mq[$];
    logic [8:0] expQ[$];
    int         tmr = 0;
    int         hsCount = 0;
    int         nChecks = 0;
    int         nFails = 0;

    always #5 clock = ~clock;

    bulk_ep_in_packetiser #(
        .DEPTH(DEPTH),
        .MAX_PKT(MAX_PKT),
        .PACKET_MODE(PACKET_MODE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .s_tlast_i(s_tlast_i),
        .s_tdata_i(s_tdata_i),
        .ep_xfer_i(ep_xfer_i),
        .ep_has_data_o(ep_has_data_o),
        .ep_tvalid_o(ep_tvalid_o),
        .ep_tready_i(ep_tready_i),
        .ep_tlast_o(ep_tlast_o),
        .ep_tdata_o(ep_tdata_o),
        .level_o(level_o),
        .full_o(full_o)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit modelHasData();
        bit anyFrame = 1'b0;
        foreach (mq[i]) if (mq[i][8]) anyFrame = 1'b1;
        return anyFrame || (mq.size() >= MAX_PKT) ||
               ((TIMEOUT != 0) && (tmr == TIMEOUT) && (mq.size() > 0));
    endfunction

    // One clock: the model decides acceptance from its own occupancy, then
    // inputs may change again 2 time units after the edge.
    task automatic step();
        bit         acc, hs;
        int         sz;
        logic [8:0] beat;
        sz   = mq.size();
        acc  = s_tvalid_i && (sz < DEPTH);
        hs   = ep_tvalid_o && ep_tready_i && ep_xfer_i;
        beat = {s_tlast_i, s_tdata_i};
        @(posedge clock);
        #2;
        if (acc) begin
            mq.push_back(beat);
            tmr = 0;
        end else if (sz > 0 && tmr < TIMEOUT) begin
            tmr++;
        end
        if (hs) hsCount++;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, ".level"}, int'(level_o), mq.size());
        checkOutput({tag, ".full"}, int'(full_o), int'(mq.size() == DEPTH));
        checkOutput({tag, ".s_tready"}, int'(s_tready_o), int'(mq.size() < DEPTH));
        checkOutput({tag, ".has_data"}, int'(ep_has_data_o), int'(modelHasData()));
        checkOutput({tag, ".tvalid_idle"}, int'(ep_tvalid_o), 0);
    endtask

    // base < 0 selects random bytes, otherwise base, base+1, ...
    task automatic applyStimulus(input int n, input bit lastAtEnd, input int base);
        for (int i = 0; i < n; i++) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = (base < 0) ? 8'($urandom) : 8'(base + i);
            s_tlast_i  = lastAtEnd && (i == n - 1);
            step();
        end
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    // Expected packet: up to MAX_PKT committed bytes, cut at the first frame end.
    function automatic int buildExpected();
        int n, len;
        n   = (mq.size() < MAX_PKT) ? mq.size() : MAX_PKT;
        len = 0;
        for (int i = 0; i < n; i++) begin
            len = i + 1;
            if (mq[i][8]) break;
        end
        for (int i = 0; i < len; i++) begin
            expQ.push_back({(i == len - 1) ? 1'b1 : 1'b0, mq[i][7:0]});
        end
        return len;
    endfunction

    task automatic doTransfer(input int abortAt, input bit wrDuring);
        int len, cyc;
        bit aborted;
        if (!modelHasData()) return;
        len       = buildExpected();
        hsCount   = 0;
        cyc       = 0;
        ep_xfer_i = 1'b1;
        while (hsCount < len) begin
            if (abortAt >= 0 && cyc > 0 && hsCount >= abortAt) break;
            ep_tready_i = ($urandom_range(0, 3) != 0);
            if (wrDuring) begin
                s_tvalid_i = $urandom_range(0, 1);
                s_tdata_i  = 8'($urandom);
                s_tlast_i  = ($urandom_range(0, 7) == 0);
            end
            step();
            cyc++;
            if (cyc > 20 * len + 40) begin
                checkOutput("xfer_timeout.handshakes", hsCount, len);
                break;
            end
        end
        aborted     = (hsCount < len);
        ep_xfer_i   = 1'b0;
        ep_tready_i = 1'b0;
        s_tvalid_i  = 1'b0;
        s_tlast_i   = 1'b0;
        if (!aborted) begin
            repeat (len) void'(mq.pop_front());
            checkOutput("s_tready_after_commit", int'(s_tready_o), int'(mq.size() < DEPTH));
        end
        step();
        checkOutput("pkt_unsent_bytes", expQ.size(), aborted ? len - hsCount : 0);
        expQ.delete();
    endtask

    // Monitor: every real handshake must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset_n && ep_tvalid_o && ep_tready_i && ep_xfer_i) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_beat", int'(ep_tdata_o), -1);
            end else begin
                logic [8:0] e;
                e = expQ.pop_front();
                checkOutput("tdata", int'(ep_tdata_o), int'(e[7:0]));
                checkOutput("tlast", int'(ep_tlast_o), int'(e[8]));
            end
        end
    end

    initial begin
        int len, cyc;

        // Reset values while reset is held
        repeat (3) @(posedge clock);
        #2;
        checkOutput("rst.s_tready", int'(s_tready_o), 1);
        checkOutput("rst.has_data", int'(ep_has_data_o), 0);
        checkOutput("rst.tvalid", int'(ep_tvalid_o), 0);
        checkOutput("rst.tlast", int'(ep_tlast_o), 0);
        checkOutput("rst.tdata", int'(ep_tdata_o), 0);
        checkOutput("rst.level", int'(level_o), 0);
        checkOutput("rst.full", int'(full_o), 0);
        reset_n = 1'b1;
        step();
        checkStatus("post_rst");

        // 10-byte frame 0x00..0x09 splits into 8 + 2
        applyStimulus(10, 1'b1, 0);
        checkStatus("frame10");
        doTransfer(-1, 1'b0);
        checkStatus("frame10.pkt1");
        doTransfer(-1, 1'b0);
        checkStatus("frame10.pkt2");

        // Transfer request with nothing buffered is NAKed
        ep_xfer_i = 1'b1;
        repeat (5) begin
            step();
            checkStatus("nak");
        end
        ep_xfer_i = 1'b0;
        step();

        // Abort mid-packet and in the prefetch cycle, then replay
        applyStimulus(6, 1'b1, 8'h40);
        doTransfer(3, 1'b0);
        checkStatus("abort_mid");
        doTransfer(0, 1'b0);
        checkStatus("abort_load");
        doTransfer(-1, 1'b0);
        checkStatus("replay");

        // Fill past capacity without a frame end
        applyStimulus(DEPTH + 3, 1'b0, -1);
        checkStatus("full");
        doTransfer(-1, 1'b0);
        checkStatus("after_full");
        for (int k = 0; k < 10 && modelHasData(); k++) doTransfer(-1, 1'b0);
        checkStatus("drained");

        // Idle flush of a partial packet
        applyStimulus(3, 1'b0, 8'h70);
        for (int c = 0; c < TIMEOUT + 3; c++) begin
            checkStatus("flush_wait");
            step();
        end
        doTransfer(-1, 1'b0);
        checkStatus("flush_done");

        // Randomised traffic
        repeat (80) begin
            case ($urandom_range(0, 3))
                0: applyStimulus($urandom_range(1, 12), $urandom_range(0, 1), -1);
                1: begin
                    repeat ($urandom_range(1, 25)) begin
                        step();
                        checkStatus("rnd_idle");
                    end
                end
                2: doTransfer(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAX_PKT - 1)) : -1,
                              $urandom_range(0, 1));
                default: begin
                    applyStimulus($urandom_range(1, 12), $urandom_range(0, 1), -1);
                    doTransfer(-1, 1'b1);
                end
            endcase
            checkStatus("rnd");
        end

        // Asynchronous reset in the middle of a packet
        applyStimulus(8, 1'b1, 8'h20);
        len         = buildExpected();
        hsCount     = 0;
        cyc         = 0;
        ep_xfer_i   = 1'b1;
        ep_tready_i = 1'b1;
        while (hsCount < 2 && cyc < 20) begin
            step();
            cyc++;
        end
        checkOutput("rst_mid.reached_send", int'(hsCount >= 2 && len > 2), 1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid.tvalid", int'(ep_tvalid_o), 0);
        checkOutput("rst_mid.tlast", int'(ep_tlast_o), 0);
        checkOutput("rst_mid.tdata", int'(ep_tdata_o), 0);
        checkOutput("rst_mid.level", int'(level_o), 0);
        checkOutput("rst_mid.full", int'(full_o), 0);
        checkOutput("rst_mid.s_tready", int'(s_tready_o), 1);
        checkOutput("rst_mid.has_data", int'(ep_has_data_o), 0);
        mq.delete();
        expQ.delete();
        tmr         = 0;
        ep_xfer_i   = 1'b0;
        ep_tready_i = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        step();
        checkStatus("after_rst_mid");

        // Fresh frame after the reset still works
        applyStimulus(5, 1'b1, 8'h90);
        doTransfer(-1, 1'b0);
        checkStatus("final");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
